branch_resolution_sequencer: RTL and testbench

Sequences the life of one speculative branch between fetch-side prediction and execute-side resolution. It latches the predicted next-PC when speculation begins and compares it with the resolved outcome. It generates the one-cycle end/mispredict pulses consumed by the branch examiner and predictors, and on a mispredict runs a flush-then-redirect sequence toward the fetch stage. It sits between the branch examiner, the fetch PC logic and the branch execution unit.

---
 rtl/branch_resolution_sequencer_pkg.sv | 14 +
 rtl/branch_resolution_sequencer_stats.sv | 26 ++
 rtl/branch_resolution_sequencer.sv | 175 +++++++++++++++++
 tb/tb_branch_resolution_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolution_sequencer_pkg.sv
// Shared types and constants for the branch resolution sequencer.
package branch_resolution_sequencer_pkg;

    localparam int unsigned FLUSH_CNT_W = 4;
    localparam int unsigned STATS_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SPEC     = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } brs_state_e;

endpackage

// File: rtl/branch_resolution_sequencer_stats.sv
// Saturating event counter used for resolution statistics.
// Only compiled when BRANCH_RESOLUTION_STATS_EN is defined.
`ifdef BRANCH_RESOLUTION_STATS_EN
module branch_stats_counter
    import branch_resolution_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_inc,
    output logic [STATS_CNT_W-1:0] o_count
);

    logic [STATS_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + STATS_CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/branch_resolution_sequencer.sv
// Tracks one speculative branch from prediction to resolution; on mispredict runs flush then redirect.
// Optional BRANCH_RESOLUTION_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolution_sequencer
    import branch_resolution_sequencer_pkg::*;
#(
    parameter int unsigned DATABITWIDTH = 16,
    parameter int unsigned FLUSHCYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    clk_en,
    input  logic                    sync_rst,
    input  logic                    BeginSpeculationPulse,
    input  logic                    PredictingTrue,
    input  logic [DATABITWIDTH-1:0] SpeculativeDestination,
    input  logic [DATABITWIDTH-1:0] FetchedInstructionAddress,
    input  logic                    ResolveValid,
    input  logic                    ResolvedTaken,
    input  logic [DATABITWIDTH-1:0] ResolvedDestination,
    output logic                    EndSpeculationPulse,
    output logic                    MispredictedSpeculationPulse,
    output logic [DATABITWIDTH-1:0] ActualDestination,
    output logic                    PipelineFlush,
    output logic                    FetchRedirect,
    output logic [DATABITWIDTH-1:0] RedirectAddress,
    output logic                    Busy
`ifdef BRANCH_RESOLUTION_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0]  ResolvedCount,
    output logic [STATS_CNT_W-1:0]  MispredictCount
`endif
);

    localparam int unsigned W = DATABITWIDTH;
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSHCYCLES - 1);

    brs_state_e             r_state;
    brs_state_e             w_state_nxt;
    logic [W-1:0]           r_fall;
    logic [W-1:0]           w_fall_nxt;
    logic [W-1:0]           r_pred;
    logic [W-1:0]           w_pred_nxt;
    logic [W-1:0]           r_actual;
    logic [W-1:0]           w_actual_nxt;
    logic [W-1:0]           r_raddr;
    logic [W-1:0]           w_raddr_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;
    logic                   w_end_nxt;
    logic                   w_mis_nxt;
    logic                   w_redir_nxt;
    logic                   r_end;
    logic                   r_mis;
    logic                   r_flush;
    logic                   r_redir;
    logic                   r_busy;
    logic [W-1:0]           w_fa_inc;
    logic [W-1:0]           w_resolved_pc;

    assign w_fa_inc      = FetchedInstructionAddress + W'(1);
    assign w_resolved_pc = ResolvedTaken ? ResolvedDestination : r_fall;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_fall_nxt      = r_fall;
        w_pred_nxt      = r_pred;
        w_actual_nxt    = r_actual;
        w_raddr_nxt     = r_raddr;
        w_flush_cnt_nxt = r_flush_cnt;
        w_end_nxt       = 1'b0;
        w_mis_nxt       = 1'b0;
        w_redir_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (BeginSpeculationPulse) begin
                    w_fall_nxt  = w_fa_inc;
                    w_pred_nxt  = PredictingTrue ? SpeculativeDestination : w_fa_inc;
                    w_state_nxt = ST_SPEC;
                end
            end
            ST_SPEC: begin
                if (ResolveValid) begin
                    w_actual_nxt = w_resolved_pc;
                    w_end_nxt    = 1'b1;
                    if (w_resolved_pc != r_pred) begin
                        w_mis_nxt       = 1'b1;
                        w_flush_cnt_nxt = FLUSH_LOAD;
                        w_state_nxt     = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == '0) begin
                    w_redir_nxt = 1'b1;
                    w_raddr_nxt = r_actual;
                    w_state_nxt = ST_REDIRECT;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; pulses drop on disabled cycles so they never stretch
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state     <= ST_IDLE;
            r_fall      <= '0;
            r_pred      <= '0;
            r_actual    <= '0;
            r_raddr     <= '0;
            r_flush_cnt <= '0;
            r_end       <= 1'b0;
            r_mis       <= 1'b0;
            r_flush     <= 1'b0;
            r_redir     <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clk_en) begin
            r_state     <= w_state_nxt;
            r_fall      <= w_fall_nxt;
            r_pred      <= w_pred_nxt;
            r_actual    <= w_actual_nxt;
            r_raddr     <= w_raddr_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_end       <= w_end_nxt;
            r_mis       <= w_mis_nxt;
            r_flush     <= (w_state_nxt == ST_FLUSH);
            r_redir     <= w_redir_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end else begin
            r_end   <= 1'b0;
            r_mis   <= 1'b0;
            r_redir <= 1'b0;
        end
    end

    assign EndSpeculationPulse          = r_end;
    assign MispredictedSpeculationPulse = r_mis;
    assign ActualDestination            = r_actual;
    assign PipelineFlush                = r_flush;
    assign FetchRedirect                = r_redir;
    assign RedirectAddress              = r_raddr;
    assign Busy                         = r_busy;

`ifdef BRANCH_RESOLUTION_STATS_EN
    logic w_res_inc;
    logic w_mis_inc;

    assign w_res_inc = clk_en & w_end_nxt;
    assign w_mis_inc = clk_en & w_mis_nxt;

    branch_stats_counter u_resolved_cnt (
        .clk     (clk),
        .i_rst   (sync_rst),
        .i_inc   (w_res_inc),
        .o_count (ResolvedCount)
    );

    branch_stats_counter u_mispredict_cnt (
        .clk     (clk),
        .i_rst   (sync_rst),
        .i_inc   (w_mis_inc),
        .o_count (MispredictCount)
    );
`endif

endmodule

// File: tb/tb_branch_resolution_sequencer.sv
// Bench for branch_resolution_sequencer: timeline-based reference model plus directed literal checks.
module tb_branch_resolution_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned FC = 2;

    logic          clk = 1'b0;
    logic          clk_en;
    logic          sync_rst;
    logic          beg;
    logic          pt;
    logic [DW-1:0] sd;
    logic [DW-1:0] fa;
    logic          rv;
    logic          rt;
    logic [DW-1:0] rd;

    logic          o_end;
    logic          o_mis;
    logic [DW-1:0] o_act;
    logic          o_flush;
    logic          o_redir;
    logic [DW-1:0] o_raddr;
    logic          o_busy;
`ifdef BRANCH_RESOLUTION_STATS_EN
    logic [15:0]   o_rc;
    logic [15:0]   o_mc;
`endif

    always #5 clk = ~clk;

    branch_resolution_sequencer #(
        .DATABITWIDTH (DW),
        .FLUSHCYCLES  (FC)
    ) dut (
        .clk                          (clk),
        .clk_en                       (clk_en),
        .sync_rst                     (sync_rst),
        .BeginSpeculationPulse        (beg),
        .PredictingTrue               (pt),
        .SpeculativeDestination       (sd),
        .FetchedInstructionAddress    (fa),
        .ResolveValid                 (rv),
        .ResolvedTaken                (rt),
        .ResolvedDestination          (rd),
        .EndSpeculationPulse          (o_end),
        .MispredictedSpeculationPulse (o_mis),
        .ActualDestination            (o_act),
        .PipelineFlush                (o_flush),
        .FetchRedirect                (o_redir),
        .RedirectAddress              (o_raddr),
        .Busy                         (o_busy)
`ifdef BRANCH_RESOLUTION_STATS_EN
        ,
        .ResolvedCount                (o_rc),
        .MispredictCount              (o_mc)
`endif
    );

    // Reference model: m_pos counts enabled cycles since a mispredicting resolve (0 = none pending)
    bit            m_spec;
    int            m_pos;
    logic [DW-1:0] m_fall;
    logic [DW-1:0] m_pred;
    logic [DW-1:0] m_act;
    int            m_rc;
    int            m_mc;
    logic          e_end, e_mis, e_flush, e_redir, e_busy;
    logic [DW-1:0] e_act, e_raddr;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] apc;
        if (sync_rst) begin
            m_spec = 0; m_pos = 0; m_fall = '0; m_pred = '0; m_act = '0;
            m_rc = 0; m_mc = 0;
            e_end = 0; e_mis = 0; e_flush = 0; e_redir = 0; e_busy = 0;
            e_act = '0; e_raddr = '0;
        end else if (!clk_en) begin
            e_end = 0; e_mis = 0; e_redir = 0;
        end else begin
            e_end = 0; e_mis = 0; e_redir = 0;
            if (m_pos != 0) begin
                m_pos++;
                if (m_pos > FC + 1) begin
                    m_pos = 0;
                end else if (m_pos == FC + 1) begin
                    e_redir = 1;
                    e_raddr = m_act;
                end
            end else if (m_spec) begin
                if (rv) begin
                    apc    = rt ? rd : m_fall;
                    m_act  = apc;
                    e_act  = apc;
                    e_end  = 1;
                    m_spec = 0;
                    if (m_rc < 65535) m_rc++;
                    if (apc != m_pred) begin
                        e_mis = 1;
                        m_pos = 1;
                        if (m_mc < 65535) m_mc++;
                    end
                end
            end else if (beg) begin
                m_fall = fa + DW'(1);
                m_pred = pt ? sd : m_fall;
                m_spec = 1;
            end
            e_flush = (m_pos >= 1) && (m_pos <= FC);
            e_busy  = m_spec || (m_pos != 0);
        end
    endtask

    task automatic compare();
        chk("end_pulse", o_end, e_end);
        chk("mispredict_pulse", o_mis, e_mis);
        chk("pipeline_flush", o_flush, e_flush);
        chk("fetch_redirect", o_redir, e_redir);
        chk("busy", o_busy, e_busy);
        if (e_end) chk("actual_destination", o_act, e_act);
        if (e_redir) chk("redirect_address", o_raddr, e_raddr);
`ifdef BRANCH_RESOLUTION_STATS_EN
        chk("resolved_count", o_rc, m_rc);
        chk("mispredict_count", o_mc, m_mc);
`endif
    endtask

    task automatic step(input logic r, input logic en, input logic b, input logic p,
                        input logic [DW-1:0] sdv, input logic [DW-1:0] fav,
                        input logic v, input logic tk, input logic [DW-1:0] rdv);
        sync_rst = r; clk_en = en; beg = b; pt = p; sd = sdv; fa = fav;
        rv = v; rt = tk; rd = rdv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic nop();
        step(0, 1, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic nop_dis();
        step(0, 0, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic rst_cycle();
        step(1, 1, 0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic begin_spec(input logic [DW-1:0] a, input logic p, input logic [DW-1:0] t);
        step(0, 1, 1, p, t, a, 0, 0, '0);
    endtask

    task automatic resolve(input logic tk, input logic [DW-1:0] t);
        step(0, 1, 0, 0, '0, '0, 1, tk, t);
    endtask

    initial begin
        logic [DW-1:0] r_fa, r_sd, r_rd;
        sync_rst = 1; clk_en = 1; beg = 0; pt = 0; sd = '0; fa = '0;
        rv = 0; rt = 0; rd = '0;

        rst_cycle();
        rst_cycle();
        for (int i = 0; i < 10; i++) nop();
        chk("idle_busy", o_busy, 0);
        chk("idle_flush", o_flush, 0);

        // Correct not-taken prediction
        begin_spec(16'h0040, 0, 16'h0000);
        chk("t1_busy_after_begin", o_busy, 1);
        nop();
        resolve(0, 16'h0000);
        chk("t1_end", o_end, 1);
        chk("t1_mis", o_mis, 0);
        chk("t1_act", o_act, 32'h0041);
        chk("t1_busy", o_busy, 0);
        nop();
        chk("t1_noflush", o_flush, 0);

        // Wrong taken target: flush two cycles, then redirect
        begin_spec(16'h0040, 1, 16'h0100);
        nop();
        resolve(1, 16'h0120);
        chk("t2_end", o_end, 1);
        chk("t2_mis", o_mis, 1);
        chk("t2_flush_r1", o_flush, 1);
        nop();
        chk("t2_flush_r2", o_flush, 1);
        chk("t2_noredir_r2", o_redir, 0);
        nop();
        chk("t2_redir_r3", o_redir, 1);
        chk("t2_raddr", o_raddr, 32'h0120);
        chk("t2_flush_r3", o_flush, 0);
        chk("t2_busy_r3", o_busy, 1);
        nop();
        chk("t2_busy_r4", o_busy, 0);

        // Fall-through wraps at the top of the address space
        begin_spec(16'hFFFF, 1, 16'h1234);
        resolve(0, 16'h0000);
        chk("t3_act_wrap", o_act, 32'h0000);
        chk("t3_mis", o_mis, 1);
        for (int i = 0; i < FC + 2; i++) nop();

        // Reset in the middle of a flush
        begin_spec(16'h0010, 1, 16'h0200);
        resolve(0, 16'h0000);
        chk("t4_flush_before_rst", o_flush, 1);
        rst_cycle();
        chk("t4_flush_after_rst", o_flush, 0);
        chk("t4_busy_after_rst", o_busy, 0);
        for (int i = 0; i < FC + 3; i++) begin
            nop();
            chk("t4_no_redirect", o_redir, 0);
        end

        // Clock enable dropped mid-flush stretches it without repeating pulses
        begin_spec(16'h0020, 0, 16'h0000);
        resolve(1, 16'h0300);
        chk("t5_end", o_end, 1);
        chk("t5_mis", o_mis, 1);
        for (int i = 0; i < 3; i++) begin
            nop_dis();
            chk("t5_flush_held", o_flush, 1);
            chk("t5_end_quiet", o_end, 0);
            chk("t5_mis_quiet", o_mis, 0);
        end
        nop();
        chk("t5_flush_last", o_flush, 1);
        nop();
        chk("t5_redir", o_redir, 1);
        chk("t5_raddr", o_raddr, 32'h0300);
`ifdef BRANCH_RESOLUTION_STATS_EN
        chk("t5_resolved_count", o_rc, 1);
        chk("t5_mispredict_count", o_mc, 1);
`endif
        nop();

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0: r_fa = 16'h0040;
                1: r_fa = 16'hFFFF;
                default: r_fa = DW'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: r_sd = r_fa + DW'(1);
                1: r_sd = 16'h0100;
                default: r_sd = DW'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: r_rd = 16'h0100;
                1: r_rd = m_fall;
                default: r_rd = DW'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 3), 1'($urandom), r_sd, r_fa,
                 ($urandom_range(0, 9) < 3), 1'($urandom), r_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
